// File: rtl/sweep_capture_ctrl_if.sv
// rtl/sweep_capture_ctrl_if.sv - handshake and capture bus bundle for sweep_capture_ctrl
// master is the controller side; slave is the MMCM/FIFO/BRAM environment side.
interface sweep_capture_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 40,
  parameter int STEP_W = 3
);
  logic              start;
  logic              abort;
  logic              mmcm_lock;
  logic              step_req;
  logic [STEP_W-1:0] step_idx;
  logic              dut_en;
  logic              fifo_clear;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic [DATA_W-1:0] golden;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [ADDR_W:0]   err_count;
  logic              err_valid;
  logic              lock_fail;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, mmcm_lock, fifo_empty, fifo_dout, golden,
    output step_req, step_idx, dut_en, fifo_clear, fifo_rd_en, bram_we,
           bram_addr, bram_din, err_count, err_valid, lock_fail, busy, done
  );

  modport slave (
    output start, abort, mmcm_lock, fifo_empty, fifo_dout, golden,
    input  step_req, step_idx, dut_en, fifo_clear, fifo_rd_en, bram_we,
           bram_addr, bram_din, err_count, err_valid, lock_fail, busy, done
  );
endinterface

// File: rtl/sweep_capture_ctrl.sv
// rtl/sweep_capture_ctrl.sv - frequency-sweep capture controller
// Steps the MMCM, streams DEPTH FIFO words per step into BRAM and counts golden mismatches.
module sweep_capture_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 40,
  parameter int NUM_STEPS = 8,
  parameter int CLR_CYC   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sweep_capture_ctrl_if.master bus
);
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int CNT_W  = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  localparam logic [ADDR_W:0]   DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LAST_RD   = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0]  CLR_LAST  = CNT_W'(CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RECONF, S_RUN, S_DRAIN, S_REPORT
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W:0]   rd_cnt_q;
  logic [STEP_W-1:0] step_idx_q;
  logic              step_req_q;
  logic              dut_en_q;
  logic              fifo_clear_q;
  logic              bram_we_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [ADDR_W:0]   err_count_q;
  logic              err_valid_q;
  logic              lock_fail_q;
  logic              done_q;

  logic              rd_en;
  logic              mismatch;
  logic              go_clear;
  logic [DATA_W-1:0] din_gated;

  // Read strobe is combinational so an empty FIFO or a lost lock never sees a read.
  assign rd_en = (state_q == S_RUN) && !bus.fifo_empty && bus.mmcm_lock &&
                 !bus.abort && !rst && (rd_cnt_q != DEPTH_C);

  assign mismatch  = (bus.fifo_dout != bus.golden);
  assign din_gated = bram_we_q ? bus.fifo_dout : '0;

  always_comb begin
    go_clear = 1'b0;
    case (state_q)
      S_IDLE:   go_clear = bus.start;
      S_RUN:    go_clear = !bus.mmcm_lock;
      S_REPORT: go_clear = (step_idx_q != LAST_STEP);
      default:  go_clear = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rd_cnt_q     <= '0;
      step_idx_q   <= '0;
      step_req_q   <= 1'b0;
      dut_en_q     <= 1'b0;
      fifo_clear_q <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      err_count_q  <= '0;
      err_valid_q  <= 1'b0;
      lock_fail_q  <= 1'b0;
      done_q       <= 1'b0;
    end else if (bus.abort) begin
      state_q      <= S_IDLE;
      step_req_q   <= 1'b0;
      dut_en_q     <= 1'b0;
      fifo_clear_q <= 1'b1;
      bram_we_q    <= 1'b0;
      err_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      step_req_q  <= 1'b0;
      err_valid_q <= 1'b0;
      done_q      <= 1'b0;
      bram_we_q   <= rd_en;
      if (rd_en) begin
        rd_cnt_q <= rd_cnt_q + (ADDR_W+1)'(1);
      end
      // Address parks on the last word; only a new capture brings it back to 0.
      if (bram_we_q) begin
        if (bram_addr_q != LAST_ADDR) begin
          bram_addr_q <= bram_addr_q + ADDR_W'(1);
        end
        if (mismatch && (err_count_q != DEPTH_C)) begin
          err_count_q <= err_count_q + (ADDR_W+1)'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          fifo_clear_q <= 1'b0;
          if (bus.start) begin
            step_idx_q  <= '0;
            lock_fail_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (cnt_q == CLR_LAST) begin
            state_q      <= S_RECONF;
            fifo_clear_q <= 1'b0;
            step_req_q   <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RECONF: begin
          if ((cnt_q != '0) && bus.mmcm_lock) begin
            state_q  <= S_RUN;
            dut_en_q <= 1'b1;
          end else begin
            cnt_q <= CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!bus.mmcm_lock) begin
            lock_fail_q <= 1'b1;
            dut_en_q    <= 1'b0;
            bram_we_q   <= 1'b0;
          end else if (rd_en && (rd_cnt_q == LAST_RD)) begin
            dut_en_q <= 1'b0;
            state_q  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state_q     <= S_REPORT;
          err_valid_q <= 1'b1;
        end
        S_REPORT: begin
          if (step_idx_q == LAST_STEP) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            step_idx_q <= step_idx_q + STEP_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (go_clear) begin
        state_q      <= S_CLEAR;
        fifo_clear_q <= 1'b1;
        cnt_q        <= '0;
        rd_cnt_q     <= '0;
        bram_addr_q  <= '0;
        err_count_q  <= '0;
      end
    end
  end

  assign bus.step_req   = step_req_q;
  assign bus.step_idx   = step_idx_q;
  assign bus.dut_en     = dut_en_q;
  assign bus.fifo_clear = fifo_clear_q | rst;
  assign bus.fifo_rd_en = rd_en;
  assign bus.bram_we    = bram_we_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_din   = din_gated;
  assign bus.err_count  = err_count_q;
  assign bus.err_valid  = err_valid_q;
  assign bus.lock_fail  = lock_fail_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
endmodule

// File: doc/sweep_capture_ctrl.md
SWEEP_CAPTURE_CTRL -- requirements
Module: sweep_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9: capture BRAM address width; DEPTH = 2**ADDR_W words captured per step.
REQ-002 SHALL have parameter DATA_W, default 40: DUT/FIFO/BRAM data width.
REQ-003 SHALL have parameter NUM_STEPS, default 8: MMCM frequency steps per sweep, at least 1; STEP_W = clog2(NUM_STEPS), min 1.
REQ-004 SHALL have parameter CLR_CYC, default 8: fifo_clear assertion length in cycles, at least 1.
REQ-005 Ports, clock and reset first. This block has one clock; reset is synchronous and active-high.
- clk  in  1  200 MHz control clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a sweep.
- abort  in  1  level; forces return to IDLE.
- mmcm_lock  in  1  MMCM lock status.
- step_req  out  1  one-cycle pulse that requests an MMCM reconfiguration to step_idx.
- step_idx  out  STEP_W  current frequency step.
- dut_en  out  1  DUT enable.
- fifo_clear  out  1  async FIFO reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe; dout is valid 1 cycle later.
- fifo_dout  in  DATA_W  FIFO read data.
- golden  in  DATA_W  expected word for bram_addr, valid in the same cycle as bram_we.
- bram_we  out  1  capture write strobe.
- bram_addr  out  ADDR_W  capture write address.
- bram_din  out  DATA_W  capture write data.
- err_count  out  ADDR_W+1  mismatch count for the current step.
- err_valid  out  1  one-cycle pulse when err_count is final for step_idx.
- lock_fail  out  1  sticky flag: lock was lost during RUN in this sweep.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at sweep completion.

Function
REQ-006 SHALL implement the FSM states IDLE, CLEAR, RECONF, RUN, DRAIN, REPORT.
REQ-007 IDLE: on start, SHALL go to CLEAR with step_idx=0, and SHALL clear lock_fail. start is ignored in every other state.
REQ-008 CLEAR: fifo_clear SHALL be high for exactly CLR_CYC cycles, and bram_addr and err_count SHALL be zeroed; the FSM then goes to RECONF.
REQ-009 RECONF: step_req SHALL pulse on the first cycle; the FSM SHALL wait at least 2 cycles, then until mmcm_lock=1, then go to RUN.
REQ-010 RUN: dut_en=1; fifo_rd_en SHALL be asserted when fifo_empty=0 and (reads issued − words written) < DEPTH remaining; no read is ever issued with fifo_empty=1.
REQ-011 Write path: in the cycle after each fifo_rd_en, bram_we=1, bram_din=fifo_dout, and bram_addr takes the current write address; the address increments after the write. Read-to-write latency SHALL be exactly 1 cycle.
REQ-012 Compare: on each bram_we, if fifo_dout≠golden, err_count SHALL increment by 1; err_count saturates at DEPTH (DEPTH fits in ADDR_W+1 bits, so it never wraps).
REQ-013 When the DEPTH-th read is issued, the FSM SHALL drop dut_en and go to DRAIN; DRAIN SHALL complete the final write, then go to REPORT.
REQ-014 REPORT: err_valid SHALL pulse for one cycle with err_count and step_idx stable. If step_idx=NUM_STEPS−1, the FSM pulses done and goes to IDLE; otherwise it increments step_idx and goes to CLEAR.
REQ-015 Lock loss (mmcm_lock=0) in RUN: SHALL set lock_fail, drop dut_en, discard any pending write, and return to CLEAR for the same step_idx, which restarts the capture from address 0.
REQ-016 abort=1 in any state SHALL go to IDLE next cycle with all strobes low and fifo_clear pulsed for 1 cycle; step_idx, err_count and lock_fail hold their values.
REQ-017 bram_addr SHALL wrap from DEPTH−1 to 0 only via CLEAR; it SHALL never exceed DEPTH−1 within one step.
REQ-018 step_req, err_valid and done SHALL each be exactly 1 cycle wide, and SHALL never be asserted in the same cycle as each other.

Reset
REQ-019 rst=1 SHALL force IDLE on the next edge; all outputs SHALL be 0 except fifo_clear=1 while rst is high.
REQ-020 rst has priority over abort and start.
REQ-021 rst asserted mid-RUN SHALL terminate the sweep without producing err_valid or done.

Verification
REQ-022 NUM_STEPS=2, ADDR_W=4, FIFO always non-empty, golden=fifo_dout -> exactly 16 bram_we per step, addresses 0..15, err_valid twice with err_count=0, done once.
REQ-023 Golden differs on addresses 3 and 9 -> err_count=2 at that step's err_valid.
REQ-024 fifo_empty toggling every other cycle -> no fifo_rd_en while empty, still 16 writes, and every write occurs 1 cycle after its read.
REQ-025 mmcm_lock dropped at write 7 of step 0 -> lock_fail=1, CLEAR re-entered with step_idx=0, and a full 16-word recapture.
REQ-026 abort during RECONF, then start -> back in IDLE within 1 cycle and a fresh sweep from step_idx=0 with lock_fail cleared.
REQ-027 rst pulse during DRAIN -> IDLE, no err_valid, fifo_clear high while rst is high.
